// File: rtl/f32_pkg.sv
// Shared FP32 package for the divider and the multiplier.
// Provides the control state type, the format constants and the
// operand classification helpers. It has no ports.
package f32_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    DIVIDE    = 3'd2,
    NORMALIZE = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam int          BIAS      = 127;
  localparam logic [7:0]  EXP_INF   = 8'hFF;
  localparam logic [31:0] RES_EXC   = 32'h7FFFFFFF;
  localparam int          DIV_ITERS = 25;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == EXP_INF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == EXP_INF) && (x[22:0] == 23'd0);
  endfunction

  // Denormals are flushed, so any zero exponent is treated as zero.
  function automatic logic is_zero_or_denorm(input logic [31:0] x);
    return (x[30:23] == 8'd0);
  endfunction

endpackage

// File: rtl/f32_mant_div.sv
// Restoring mantissa divider: one quotient bit per clock, DIV_ITERS bits.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        start a new division with m_a / m_b
//   m_a, m_b    24-bit mantissas {1, frac}; m_b must stay stable while running
//   quotient    25-bit quotient accumulator, bit 24 is the integer bit
//   last        high during the cycle whose step produces the final bit
module f32_mant_div
  import f32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [23:0] m_a,
  input  logic [23:0] m_b,
  output logic [24:0] quotient,
  output logic        last
);

  logic [24:0] rem_r;
  logic [24:0] qacc_r;
  logic [4:0]  iter_r;
  logic        run_r;
  logic        ge_s;
  logic [24:0] diff_s;

  // Trial subtraction of the divisor from the partial remainder.
  always_comb begin
    ge_s   = (rem_r >= {1'b0, m_b});
    diff_s = rem_r;
    if (ge_s) begin
      diff_s = rem_r - {1'b0, m_b};
    end else begin
      diff_s = rem_r;
    end
  end

  // Remainder, quotient accumulator and iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_r  <= 25'd0;
      qacc_r <= 25'd0;
      iter_r <= 5'd0;
      run_r  <= 1'b0;
    end else if (load) begin
      rem_r  <= {1'b0, m_a};
      qacc_r <= 25'd0;
      iter_r <= 5'(DIV_ITERS - 1);
      run_r  <= 1'b1;
    end else if (run_r) begin
      // After a successful subtract the remainder is below m_b, so the shift cannot overflow.
      rem_r  <= {diff_s[23:0], 1'b0};
      qacc_r <= {qacc_r[23:0], ge_s};
      if (iter_r == 5'd0) begin
        run_r <= 1'b0;
      end else begin
        iter_r <= iter_r - 5'd1;
      end
    end
  end

  assign quotient = qacc_r;
  assign last     = run_r && (iter_r == 5'd0);

endmodule

// File: rtl/f32_div.sv
// Sequential FP32 divider q = a / b with start/done handshake.
// Denormals are flushed to zero, rounding is truncation.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   a, b           dividend and divisor, captured when start is seen in IDLE
//   start          request, ignored unless idle
//   busy           high in every state except IDLE
//   done           one-cycle pulse when q and flags become valid
//   q              registered quotient
//   overflow_o     result overflow or infinite operand
//   underflow_o    result flushed to zero
//   div_by_zero_o  divisor zero or denormal
module f32_div
  import f32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] q,
  output logic        overflow_o,
  output logic        underflow_o,
  output logic        div_by_zero_o
);

  state_t             state_r;
  state_t             state_nxt;
  logic [31:0]        a_r;
  logic [31:0]        b_r;
  logic               capture_s;
  logic               load_s;
  logic               upd_s;
  logic [31:0]        q_nxt;
  logic               ov_nxt;
  logic               un_nxt;
  logic               dz_nxt;
  logic [24:0]        quot_s;
  logic               last_s;
  logic               sign_s;
  logic [22:0]        mant_s;
  logic signed [9:0]  exp_s;
  logic [31:0]        q_r;
  logic               busy_r;
  logic               done_r;
  logic               ov_r;
  logic               un_r;
  logic               dz_r;

  assign sign_s = a_r[31] ^ b_r[31];
  // Ranges from -127 to 380, so 10 signed bits hold it without wrap.
  assign exp_s  = {2'b00, a_r[30:23]} - {2'b00, b_r[30:23]} + 10'(BIAS - 1) + {9'd0, quot_s[24]};

  f32_mant_div u_mant_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_s),
    .m_a      ({1'b1, a_r[22:0]}),
    .m_b      ({1'b1, b_r[22:0]}),
    .quotient (quot_s),
    .last     (last_s)
  );

  // Select the 23 fraction bits below the leading one of the quotient.
  always_comb begin
    mant_s = 23'd0;
    if (quot_s[24]) begin
      mant_s = quot_s[23:1];
    end else begin
      mant_s = quot_s[22:0];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic, special-case handling and result formation.
  always_comb begin
    state_nxt = state_r;
    capture_s = 1'b0;
    load_s    = 1'b0;
    upd_s     = 1'b0;
    q_nxt     = 32'h0000_0000;
    ov_nxt    = 1'b0;
    un_nxt    = 1'b0;
    dz_nxt    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          capture_s = 1'b1;
          state_nxt = LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      LOAD: begin
        if (is_nan(a_r) || is_nan(b_r)) begin
          upd_s     = 1'b1;
          state_nxt = DONE;
        end else if (is_inf(a_r) || is_inf(b_r)) begin
          upd_s     = 1'b1;
          q_nxt     = RES_EXC;
          ov_nxt    = 1'b1;
          state_nxt = DONE;
        end else if (is_zero_or_denorm(b_r)) begin
          upd_s     = 1'b1;
          q_nxt     = RES_EXC;
          ov_nxt    = 1'b1;
          dz_nxt    = 1'b1;
          state_nxt = DONE;
        end else if (is_zero_or_denorm(a_r)) begin
          upd_s     = 1'b1;
          q_nxt     = {sign_s, 31'd0};
          state_nxt = DONE;
        end else begin
          load_s    = 1'b1;
          state_nxt = DIVIDE;
        end
      end
      DIVIDE: begin
        if (last_s) begin
          state_nxt = NORMALIZE;
        end else begin
          state_nxt = DIVIDE;
        end
      end
      NORMALIZE: begin
        upd_s     = 1'b1;
        state_nxt = DONE;
        if (exp_s >= 10'sd255) begin
          q_nxt  = RES_EXC;
          ov_nxt = 1'b1;
        end else if (exp_s <= 10'sd0) begin
          q_nxt  = {sign_s, 31'd0};
          un_nxt = 1'b1;
        end else begin
          q_nxt  = {sign_s, exp_s[7:0], mant_s};
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture on an accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= 32'd0;
      b_r <= 32'd0;
    end else if (capture_s) begin
      a_r <= a;
      b_r <= b;
    end
  end

  // Registered handshake, result and flags; flags are always written as a set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      q_r    <= 32'd0;
      ov_r   <= 1'b0;
      un_r   <= 1'b0;
      dz_r   <= 1'b0;
    end else begin
      busy_r <= (state_nxt != IDLE);
      done_r <= (state_nxt == DONE);
      if (upd_s) begin
        q_r  <= q_nxt;
        ov_r <= ov_nxt;
        un_r <= un_nxt;
        dz_r <= dz_nxt;
      end
    end
  end

  assign busy          = busy_r;
  assign done          = done_r;
  assign q             = q_r;
  assign overflow_o    = ov_r;
  assign underflow_o   = un_r;
  assign div_by_zero_o = dz_r;

endmodule

// File: tb/tb_f32_div.sv
// Scoreboard bench for f32_div: stimulus pushes expected results computed
// with plain integer arithmetic; a monitor pops them on every done pulse.
module tb_f32_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a_in = 32'd0;
  logic [31:0] b_in = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic        overflow_o;
  logic        underflow_o;
  logic        div_by_zero_o;

  typedef struct {
    logic [31:0] q;
    logic [2:0]  fl;   // {overflow, underflow, div_by_zero}
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   start_q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  int   last_done = 0;
  int   prev_done = 0;

  f32_div dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .a             (a_in),
    .b             (b_in),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .q             (q),
    .overflow_o    (overflow_o),
    .underflow_o   (underflow_o),
    .div_by_zero_o (div_by_zero_o)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: exact quotient floor(m_a * 2^24 / m_b), then the format rules.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t        r;
    logic [7:0]  ex, ey;
    logic [22:0] fx, fy;
    logic        sg, ib;
    logic [63:0] mx, my, qt;
    logic [22:0] mant;
    int          e;
    ex = x[30:23]; ey = y[30:23];
    fx = x[22:0];  fy = y[22:0];
    sg = x[31] ^ y[31];
    r.q = 32'd0; r.fl = 3'b000; r.lat = 2;
    if ((ex == 8'hFF && fx != 23'd0) || (ey == 8'hFF && fy != 23'd0)) begin
      r.q = 32'd0;
    end else if (ex == 8'hFF || ey == 8'hFF) begin
      r.q = 32'h7FFFFFFF; r.fl = 3'b100;
    end else if (ey == 8'd0) begin
      r.q = 32'h7FFFFFFF; r.fl = 3'b101;
    end else if (ex == 8'd0) begin
      r.q = {sg, 31'd0};
    end else begin
      r.lat = 28;
      mx = {40'd0, 1'b1, fx};
      my = {40'd0, 1'b1, fy};
      qt = (mx << 24) / my;
      ib = qt[24];
      mant = ib ? qt[23:1] : qt[22:0];
      e = int'(ex) - int'(ey) + 126 + int'(ib);
      if (e >= 255) begin
        r.q = 32'h7FFFFFFF; r.fl = 3'b100;
      end else if (e <= 0) begin
        r.q = {sg, 31'd0}; r.fl = 3'b010;
      end else begin
        r.q = {sg, e[7:0], mant};
      end
    end
    return r;
  endfunction

  // Monitor: pop and compare on every done pulse.
  initial begin
    exp_t e;
    int   s;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        done_cnt++;
        prev_done = last_done;
        last_done = cyc;
        if (exp_q.size() == 0 || start_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done actual q=%h required no done", q);
        end else begin
          e = exp_q.pop_front();
          s = start_q.pop_front();
          chk("q", {32'd0, q}, {32'd0, e.q});
          chk("flags", {61'd0, overflow_o, underflow_o, div_by_zero_o}, {61'd0, e.fl});
          chk("latency", 64'(cyc - s + 1), 64'(e.lat));
        end
      end
    end
  end

  task automatic wait_empty();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #2;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL timeout actual pending=%0d required 0", exp_q.size());
      exp_q.delete();
      start_q.delete();
    end
  endtask

  // Issue one request, then scramble the inputs while the DUT is busy.
  task automatic do_op(input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    a_in  = x;
    b_in  = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(model(x, y));
    start_q.push_back(cyc);
    start = 1'b0;
    a_in  = $urandom;
    b_in  = $urandom;
    wait_empty();
  endtask

  function automatic logic [31:0] rand_fp();
    int          k;
    logic [7:0]  e;
    logic [22:0] f;
    logic        s;
    k = $urandom_range(0, 15);
    s = 1'($urandom_range(0, 1));
    f = 23'($urandom);
    case (k)
      0:       begin e = 8'hFF; if (f == 23'd0) f = 23'd1; end
      1:       begin e = 8'hFF; f = 23'd0; end
      2:       e = 8'd0;
      3:       e = ($urandom_range(0, 1) == 0) ? 8'd1 : 8'd254;
      default: e = 8'($urandom_range(60, 194));
    endcase
    return {s, e, f};
  endfunction

  initial begin
    int s0;
    int cnt0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {28'd0, busy, done, q, overflow_o, underflow_o, div_by_zero_o}, 64'd0);
    rst_n = 1'b1;

    do_op(32'h40C00000, 32'h40000000);
    do_op(32'h3F800000, 32'h40400000);
    do_op(32'hBF800000, 32'h3F000000);
    do_op(32'h3F800000, 32'h00000000);
    do_op(32'h7FC00000, 32'h00000000);
    do_op(32'h7F000000, 32'h3E800000);
    do_op(32'h00800000, 32'h40000000);
    do_op(32'h40C00000, 32'h40000000);

    // start held high: second request accepted right after one idle cycle.
    cnt0 = done_cnt;
    @(negedge clk);
    a_in  = 32'h40C00000;
    b_in  = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    #1;
    s0 = cyc;
    exp_q.push_back(model(32'h40C00000, 32'h40000000));
    start_q.push_back(s0);
    exp_q.push_back(model(32'h3F800000, 32'h40400000));
    start_q.push_back(s0 + 29);
    a_in = 32'h3F800000;
    b_in = 32'h40400000;
    repeat (57) @(posedge clk);
    #1;
    start = 1'b0;
    wait_empty();
    repeat (3) @(posedge clk);
    chk("b2b_done_count", 64'(done_cnt - cnt0), 64'd2);
    chk("b2b_done_gap", 64'(last_done - prev_done), 64'd29);

    // Reset in the 10th DIVIDE cycle aborts the operation.
    @(negedge clk);
    a_in  = 32'h3F800000;
    b_in  = 32'h40400000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (11) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {28'd0, busy, done, q, overflow_o, underflow_o, div_by_zero_o}, 64'd0);
    cnt0 = done_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt - cnt0), 64'd0);
    do_op(32'h40C00000, 32'h40000000);

    for (int i = 0; i < 150; i++) begin
      do_op(rand_fp(), rand_fp());
    end

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/f32_div.md
Name: f32_div

Overview:
- Sequential IEEE-754 single-precision divider, q = a / b; companion to the team's FP32 multiplier.
- Same start/done handshake, the same flush-to-zero denormal policy and the same exception encodings as the multiplier.
- Mantissa quotient is computed by a 25-iteration restoring divider, one quotient bit per cycle.
- Sits beside the multiplier behind the FP unit's operation mux.

Parameters:
- None. Iteration count (25) and bias (127) are fixed constants in the shared package.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- a  in  32  dividend, FP32
- b  in  32  divisor, FP32
- start  in  1  request; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; q and flags are valid from this cycle onward
- q  out  32  registered quotient
- overflow_o  out  1  registered; result overflow or infinite operand
- underflow_o  out  1  registered; result flushed to zero
- div_by_zero_o  out  1  registered; divisor is zero or denormal

Behaviour:
- Reset: state IDLE; busy, done, q, overflow_o, underflow_o and div_by_zero_o are all 0. Reset mid-operation aborts the operation; no done pulse follows.
- States (state_t): IDLE, LOAD, DIVIDE, NORMALIZE, DONE.
- IDLE: if start=1, capture a and b into internal registers and go to LOAD. start is ignored in every other state; a and b may change after capture.
- LOAD: decode the captured operands.
  - Sign = s_a ^ s_b.
  - Mantissas are {1, frac}.
  - Denormals count as zero.
  - Special cases set the result, the flags and go straight to DONE, in this priority order:
    1. Either operand NaN: q = 0x00000000, no flags.
    2. Either operand infinity: q = 0x7FFFFFFF, overflow_o = 1.
    3. b zero or denormal: q = 0x7FFFFFFF, overflow_o = 1, div_by_zero_o = 1.
    4. a zero or denormal: q = {sign, 31'b0}, no flags.
  - Otherwise: load R = {1'b0, m_a} (25 bits), clear Qacc, set iter = 24, go to DIVIDE.
- DIVIDE: one iteration per cycle, 25 cycles.
  - If R >= {0, m_b}: qbit = 1 and R -= m_b; else qbit = 0.
  - Then R <<= 1 and Qacc = {Qacc[23:0], qbit}.
  - When iter == 0, go to NORMALIZE; else decrement iter.
- NORMALIZE:
  - Qacc[24] is the integer bit, set when m_a >= m_b.
  - Mantissa = Qacc[24] ? Qacc[23:1] : Qacc[22:0].
  - Rounding is truncation; no sticky bit is kept.
  - Exponent is 10-bit signed: e = e_a − e_b + 126 + Qacc[24].
  - e >= 255: q = 0x7FFFFFFF, overflow_o = 1.
  - e <= 0: q = {sign, 31'b0}, underflow_o = 1 (no gradual underflow).
  - Otherwise q = {sign, e[7:0], mantissa}.
  - Go to DONE.
- Output register update: q and all three flags are written on the transition into DONE. All three flags are written together (unset ones cleared) and hold until the next operation's transition into DONE.
- DONE: done = 1 for exactly one cycle; next state IDLE. A start seen in the following IDLE cycle is accepted, so back-to-back operations run with one idle cycle between them.
- Latency, counted from the edge that samples start (edge 0):
  - Normal path: done is high in cycle 28 (LOAD 1, DIVIDE 25, NORMALIZE 1, DONE 1).
  - Special-case path: done is high in cycle 2.

Decomposition:
- Shared package f32_pkg holds:
  - the state_t enum;
  - constants BIAS = 127, EXP_INF = 8'hFF, RES_EXC = 32'h7FFFFFFF, DIV_ITERS = 25;
  - operand classification functions is_nan, is_inf, is_zero_or_denorm.
  The multiplier migrates to the same package.
- One sub-module, f32_mant_div: the restoring divider datapath (R, Qacc, iteration counter).
  - Inputs: load, m_a, m_b.
  - Outputs: quotient[24:0] and a last flag.
  - The FSM stays in f32_div.

Test Plan:
- 0x40C00000 / 0x40000000 (6.0 / 2.0) -> q = 0x40400000, no flags, done exactly 28 cycles after start sampled.
- 0x3F800000 / 0x40400000 (1 / 3) -> q = 0x3EAAAAAA (truncated); 0xBF800000 / 0x3F000000 -> q = 0xC0000000.
- 0x3F800000 / 0x00000000 -> q = 0x7FFFFFFF, overflow_o = 1, div_by_zero_o = 1, done at cycle 2. 0x7FC00000 / 0x00000000 -> q = 0x00000000 (NaN has priority).
- 0x7F000000 / 0x3E800000 -> q = 0x7FFFFFFF, overflow_o = 1. 0x00800000 / 0x40000000 -> q = 0x00000000, underflow_o = 1.
- Hold start high for 40 cycles -> two results, done pulses separated by exactly one idle cycle. Change a and b while busy -> result reflects the captured operands.
- Drop rst_n at DIVIDE cycle 10 -> all outputs 0 immediately, no done. Release, run 6.0 / 2.0 -> normal result.
